loopback_skew_probe: RTL and testbench
======================================

# loopback_skew_probe

Self-test engine for the loopback project. It drives a known pattern onto the outbound pad bus and watches the same pattern return on the inbound bus. From that it measures the round-trip latency in clock cycles, and the bit-to-bit skew (first bit arriving versus last bit arriving), over a fixed number of samples. It sits inside the top-level tile, between the dedicated outputs and inputs, so the on-chip side can characterise the external loop.

## Interface
Parameters:
- WIDTH, 8, width of the looped bus
- LAT_W, 4, width of the latency counter and of the results; timeout at 2^LAT_W-1
- NSAMP, 4, number of samples per run (≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  pulse; begins a run from IDLE or DONE, ignored otherwise
- tx_data  out  WIDTH  registered pattern to the loop
- rx_data  in  WIDTH  returned bus; asynchronous, synchronized internally
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  level; held in DONE until start or rst
- timeout  out  1  run aborted, qualified by done
- lat_min  out  LAT_W  minimum all-bits-match latency
- lat_max  out  LAT_W  maximum all-bits-match latency
- skew_max  out  LAT_W  maximum of (all-match cycle − first-nonzero cycle)

## Operation
- Reset values: tx_data=0, busy=0, done=0, timeout=0, lat_min=all-ones, lat_max=0, skew_max=0, sample index=0, state IDLE.
- Accepted start applies the same clears as reset, then enters FLUSH.
- FSM states and transitions:
  - IDLE: wait for start.
  - FLUSH: tx_data=0; counter runs.
    - Synced rx==0 → SEND.
    - Counter saturates → timeout=1 → DONE.
  - SEND: one cycle; tx_data ← pattern; counter cleared → WAIT.
  - WAIT: counter increments each cycle.
    - First cycle with synced rx≠0 latches first_cnt.
    - Synced rx==pattern:
      - lat=count; update lat_min/lat_max; skew=count−first_cnt; update skew_max.
      - Increment sample index; index==NSAMP → DONE, else → FLUSH.
    - Counter saturates before a match → timeout=1 → DONE.
    - Partial or wrong values keep waiting.
  - DONE: busy=0, done=1, tx_data=0; results held.
- Timeout keeps the results accumulated from completed samples. lat_min stays all-ones if no sample completed.
- The counter saturates and never wraps. Unsigned arithmetic throughout.
- Pattern without macro: all-ones every sample, so every bit toggles.
- rst during any state: IDLE and reset values at the next edge; rst wins over a simultaneous start.
- start while busy is ignored.

## Timing
- rx_data passes through a 2-flop synchronizer before comparison.
- Direct wire loop (rx_data=tx_data) reports latency 2 and skew 0. Each extra external register stage adds 1.
- busy rises 1 cycle after start sampled high. done rises in the cycle after the final match is detected.
- A full run with a direct loop takes NSAMP×(FLUSH + SEND + WAIT) cycles. No cycle-exact total is required beyond the per-sample latency.

## Configuration
- Macro LOOPBACK_SKEW_PROBE_LFSR_EN.
  - Defined: the pattern comes from a WIDTH-bit maximal Galois LFSR (WIDTH=8: x^8+x^6+x^5+x^4+1), seed 0x01 used for sample 0, advanced once per sample. It is never zero and exercises distinct bit combinations.
  - Undefined: the pattern is constant all-ones and the LFSR logic is absent.
- Latency, skew and FSM behaviour are identical either way.

## Structure
- Package loopback_skew_probe_pkg holds:
  - the FSM state enum (IDLE, FLUSH, SEND, WAIT, DONE);
  - the LFSR tap constant for WIDTH=8;
  - default parameter constants.
- Sub-module loopback_skew_probe_sync: WIDTH-bit 2-flop synchronizer, reset to 0.

## Test plan
1. Direct loop, pulse start → done=1, timeout=0, lat_min=lat_max=2, skew_max=0.
2. Loop through 3 extra registers → lat_min=lat_max=5, skew_max=0.
3. Direct loop, bit 7 delayed by 2 extra registers (macro undefined) → lat_min=lat_max=4, skew_max=2.
4. rx_data tied 0 → WAIT timeout. After the counter saturates (15 cycles), done=1, timeout=1, busy=0, lat_min=0xF, lat_max=0.
5. rx_data stuck 0xFF → FLUSH timeout: done=1, timeout=1, no samples recorded.
6. rst asserted mid-WAIT → next cycle busy=0, tx_data=0, all outputs at reset values. A later start with a direct loop reproduces case 1.

Source files
------------

// File: rtl/loopback_skew_probe_pkg.sv
// Shared types and constants for the loopback latency/skew probe.
// LOOPBACK_SKEW_PROBE_LFSR_EN selects the LFSR pattern source.
package loopback_skew_probe_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_LAT_W = 4;
   localparam int unsigned DEF_NSAMP = 4;

   // Galois right-shift taps for x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LFSR_TAPS_W8 = 8'hB8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_SEND,
      ST_WAIT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/loopback_skew_probe_if.sv
// Control, pad-loop and result signals of the loopback probe.
interface loopback_skew_probe_if
   import loopback_skew_probe_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned LAT_W = DEF_LAT_W
);
   logic             start;
   logic [WIDTH-1:0] tx_data;
   logic [WIDTH-1:0] rx_data;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [LAT_W-1:0] lat_min;
   logic [LAT_W-1:0] lat_max;
   logic [LAT_W-1:0] skew_max;

   modport master (
      input  start, rx_data,
      output tx_data, busy, done, timeout, lat_min, lat_max, skew_max
   );

   modport slave (
      output start, rx_data,
      input  tx_data, busy, done, timeout, lat_min, lat_max, skew_max
   );
endinterface

// File: rtl/loopback_skew_probe_sync.sv
// WIDTH-bit two-flop synchronizer for the returning pad bus.
module loopback_skew_probe_sync #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;
endmodule

// File: rtl/loopback_skew_probe.sv
// Drives a pattern around the external loop and measures round-trip latency and bit skew.
// Define LOOPBACK_SKEW_PROBE_LFSR_EN for an LFSR pattern instead of all-ones.
module loopback_skew_probe
   import loopback_skew_probe_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned LAT_W = DEF_LAT_W,
   parameter int unsigned NSAMP = DEF_NSAMP
) (
   input logic                    clk,
   input logic                    rst,
   loopback_skew_probe_if.master  bus
);
   localparam int unsigned IDX_W = $clog2(NSAMP + 1);
   localparam logic [LAT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [LAT_W-1:0] first_q, first_d;
   logic             first_seen_q, first_seen_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic [LAT_W-1:0] lat_min_q, lat_min_d;
   logic [LAT_W-1:0] lat_max_q, lat_max_d;
   logic [LAT_W-1:0] skew_max_q, skew_max_d;

   logic [WIDTH-1:0] rx_s;
   logic [WIDTH-1:0] pattern;
   logic             start_acc;
   logic             sample_ok;
   logic [LAT_W-1:0] first_eff;
   logic [LAT_W-1:0] skew_now;
   logic [IDX_W-1:0] idx_inc;

   loopback_skew_probe_sync #(.WIDTH(WIDTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.rx_data),
      .q_o (rx_s)
   );

`ifdef LOOPBACK_SKEW_PROBE_LFSR_EN
   logic [WIDTH-1:0] lfsr_q, lfsr_d;

   // Seeded per run, stepped once per completed sample
   always_comb begin
      lfsr_d = lfsr_q;
      if (start_acc) begin
         lfsr_d = WIDTH'(1);
      end else if (sample_ok) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? WIDTH'(LFSR_TAPS_W8) : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= WIDTH'(1);
      else     lfsr_q <= lfsr_d;
   end

   assign pattern = lfsr_q;
`else
   assign pattern = '1;
`endif

   assign start_acc = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign sample_ok = (state_q == ST_WAIT) && (rx_s == pattern);
   // A match in the same cycle as the first nonzero bit has zero skew
   assign first_eff = first_seen_q ? first_q : cnt_q;
   assign skew_now  = cnt_q - first_eff;
   assign idx_inc   = idx_q + IDX_W'(1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      first_d      = first_q;
      first_seen_d = first_seen_q;
      idx_d        = idx_q;
      tx_d         = tx_q;
      busy_d       = busy_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      lat_min_d    = lat_min_q;
      lat_max_d    = lat_max_q;
      skew_max_d   = skew_max_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_acc) begin
               state_d      = ST_FLUSH;
               cnt_d        = '0;
               first_d      = '0;
               first_seen_d = 1'b0;
               idx_d        = '0;
               tx_d         = '0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               timeout_d    = 1'b0;
               lat_min_d    = '1;
               lat_max_d    = '0;
               skew_max_d   = '0;
            end
         end
         ST_FLUSH: begin
            if (rx_s == '0) begin
               state_d = ST_SEND;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + LAT_W'(1);
            end
         end
         ST_SEND: begin
            tx_d         = pattern;
            cnt_d        = '0;
            first_d      = '0;
            first_seen_d = 1'b0;
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + LAT_W'(1);
            if ((rx_s != '0) && !first_seen_q) begin
               first_seen_d = 1'b1;
               first_d      = cnt_q;
            end
            if (sample_ok) begin
               if (cnt_q < lat_min_q)     lat_min_d  = cnt_q;
               if (cnt_q > lat_max_q)     lat_max_d  = cnt_q;
               if (skew_now > skew_max_q) skew_max_d = skew_now;
               idx_d = idx_inc;
               tx_d  = '0;
               cnt_d = '0;
               if (idx_inc == IDX_W'(NSAMP)) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FLUSH;
               end
            end else if (cnt_q == CNT_MAX) begin
               tx_d      = '0;
               timeout_d = 1'b1;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         first_q      <= '0;
         first_seen_q <= 1'b0;
         idx_q        <= '0;
         tx_q         <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         lat_min_q    <= '1;
         lat_max_q    <= '0;
         skew_max_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
         first_seen_q <= first_seen_d;
         idx_q        <= idx_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         lat_min_q    <= lat_min_d;
         lat_max_q    <= lat_max_d;
         skew_max_q   <= skew_max_d;
      end
   end

   assign bus.tx_data  = tx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.timeout  = timeout_q;
   assign bus.lat_min  = lat_min_q;
   assign bus.lat_max  = lat_max_q;
   assign bus.skew_max = skew_max_q;
endmodule

// File: tb/tb_loopback_skew_probe.sv
// Directed bench for loopback_skew_probe with a configurable external loop model.
module tb_loopback_skew_probe;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   mode;              // 0 direct, 1 three regs, 2 bit7 +2 regs, 3 tied 0, 4 tied FF
   logic [7:0] r1, r2, r3;

   loopback_skew_probe_if #(.WIDTH(8), .LAT_W(4)) bus ();

   loopback_skew_probe #(.WIDTH(8), .LAT_W(4), .NSAMP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      r1 <= bus.tx_data;
      r2 <= r1;
      r3 <= r2;
   end

   always_comb begin
      case (mode)
         1:       bus.rx_data = r3;
         2:       bus.rx_data = {r2[7], bus.tx_data[6:0]};
         3:       bus.rx_data = 8'h00;
         4:       bus.rx_data = 8'hFF;
         default: bus.rx_data = bus.tx_data;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_results(input string tag, input logic d, input logic t,
                                input logic [3:0] mn, input logic [3:0] mx, input logic [3:0] sk);
      check({tag, "_done"},    32'(bus.done),     32'(d));
      check({tag, "_timeout"}, 32'(bus.timeout),  32'(t));
      check({tag, "_busy"},    32'(bus.busy),     32'(0));
      check({tag, "_tx"},      32'(bus.tx_data),  32'(0));
      check({tag, "_lat_min"}, 32'(bus.lat_min),  32'(mn));
      check({tag, "_lat_max"}, 32'(bus.lat_max),  32'(mx));
      check({tag, "_skew"},    32'(bus.skew_max), 32'(sk));
   endtask

   // Pulse start, confirm busy rises, then wait (bounded) for done
   task automatic run(input string tag, output int n);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      check({tag, "_busy_rise"}, 32'(bus.busy), 32'(1));
      check({tag, "_done_clr"},  32'(bus.done), 32'(0));
      n = 0;
      while (bus.done !== 1'b1 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_done_in_bound"}, 32'(bus.done), 32'(1));
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus.start = 1'b0;
      mode = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(bus.tx_data), 32'(0));
      check_results("rst", 1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      mode = 0;
      run("direct", n);
      check_results("direct", 1'b1, 1'b0, 4'd2, 4'd2, 4'd0);

      mode = 1;
      repeat (4) @(posedge clk);
      #1;
      run("reg3", n);
      check_results("reg3", 1'b1, 1'b0, 4'd5, 4'd5, 4'd0);

      mode = 2;
      repeat (4) @(posedge clk);
      #1;
      run("skew", n);
      check_results("skew", 1'b1, 1'b0, 4'd4, 4'd4, 4'd2);

      mode = 3;
      repeat (4) @(posedge clk);
      #1;
      run("wait_to", n);
      check("wait_to_not_early", 32'(n >= 15), 32'(1));
      check_results("wait_to", 1'b1, 1'b1, 4'hF, 4'h0, 4'h0);

      mode = 4;
      repeat (4) @(posedge clk);
      #1;
      run("flush_to", n);
      check("flush_to_not_early", 32'(n >= 15), 32'(1));
      check_results("flush_to", 1'b1, 1'b1, 4'hF, 4'h0, 4'h0);

      // Reset in the middle of WAIT, together with a start that must lose
      mode = 0;
      repeat (4) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_tx_pattern", 32'(bus.tx_data), 32'(8'hFF));
      check("mid_busy",       32'(bus.busy),    32'(1));
      check("mid_done",       32'(bus.done),    32'(0));
      rst = 1'b1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.start = 1'b0;
      check_results("mid_rst", 1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
      @(posedge clk); #1;
      check("mid_rst_idle_busy", 32'(bus.busy), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      run("rerun", n);
      check_results("rerun", 1'b1, 1'b0, 4'd2, 4'd2, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
